// File: rtl/fixed_to_posit_pipe.sv
// Three-stage pipelined converter: two's-complement fixed-point word
// (value = signed(in_data) * 2^-FRAC) to a posit<N,ES> word of equal width,
// rounded to nearest even, saturating at maxpos/minpos, valid/ready streaming.
module fixed_to_posit_pipe #(
  parameter int N    = 16,
  parameter int FRAC = 8,
  parameter int ES   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam int PW  = $clog2(N);
  localparam int KW  = $clog2(N) + 2;
  localparam int EFW = ES + N - 1;
  localparam int W   = 2 * N + ES + 2;

  logic                 adv;
  logic                 v1_q, v2_q, v3_q;
  logic                 sign1_q, zero1_q;
  logic [N-1:0]         mag1_q;
  logic                 sign2_q, zero2_q;
  logic signed [KW-1:0] k2_q;
  logic [N-2:0]         f2_q;
  logic [N-1:0]         out_q;

  logic [N-1:0]         mag1_d;
  logic [PW-1:0]        p_d;
  logic [PW-1:0]        sh_d;
  logic signed [KW-1:0] k_d;
  logic [N-2:0]         f_d;

  logic signed [KW-1:0] r_d;
  logic [KW-1:0]        shamt_d;
  logic [KW-1:0]        e_d;
  logic [EFW-1:0]       ef_d;
  logic [W-1:0]         x_d, xs_d;
  logic [N-2:0]         body_d;
  logic                 guard_d, sticky_d;
  logic [N-1:0]         sum_d, pmag_d, res_d;

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_data  = out_q;

  // Stage 1 magnitude; -2^(N-1) wraps to 2^(N-1) as an unsigned N-bit value.
  always_comb begin
    mag1_d = in_data[N-1] ? -in_data : in_data;
  end

  // Stage 2: msb position, scale and hidden-bit-dropped fraction.
  always_comb begin
    p_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mag1_q[i]) p_d = PW'(i);
    end
    sh_d = PW'(N - 1) - p_d;
    k_d  = KW'(p_d) - KW'(FRAC);
    f_d  = (N-1)'(mag1_q << sh_d);
  end

  // Stage 3: regime/exponent/fraction packing, RNE rounding, saturation, sign.
  // The regime is produced by shifting a 2-bit seed: "10" shifted arithmetically
  // by r yields r+1 ones then a zero; "01" shifted logically by -r-1 (= ~r)
  // yields -r zeros then a one. Exponent and fraction ride along behind it.
  always_comb begin
    r_d      = k2_q >>> ES;
    shamt_d  = r_d[KW-1] ? ~r_d : r_d;
    e_d      = $unsigned(k2_q) & KW'((1 << ES) - 1);
    ef_d     = (EFW'(e_d) << (N - 1)) | EFW'(f2_q);
    x_d      = {(r_d[KW-1] ? 2'b01 : 2'b10), ef_d, (N+1)'(0)};
    xs_d     = r_d[KW-1] ? (x_d >> shamt_d) : $unsigned($signed(x_d) >>> shamt_d);
    body_d   = xs_d[W-1 -: N-1];
    guard_d  = xs_d[W-N];
    sticky_d = |xs_d[W-N-1:0];
    sum_d    = {1'b0, body_d} + N'(guard_d & (sticky_d | body_d[0]));
    if (sum_d[N-1])       pmag_d = {1'b0, {(N-1){1'b1}}};
    else if (sum_d == '0) pmag_d = N'(1);
    else                  pmag_d = sum_d;
    if (zero2_q)          res_d = '0;
    else if (sign2_q)     res_d = -pmag_d;
    else                  res_d = pmag_d;
  end

  // Valid bits and output word: reset flushes, otherwise shift on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      out_q <= '0;
    end else if (adv) begin
      v1_q  <= in_valid;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      out_q <= res_d;
    end
  end

  // Unreset datapath registers, also shifting only on advance.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q <= in_data[N-1];
      zero1_q <= (in_data == '0);
      mag1_q  <= mag1_d;
      sign2_q <= sign1_q;
      zero2_q <= zero1_q;
      k2_q    <= k_d;
      f2_q    <= f_d;
    end
  end

endmodule
